// File: rtl/cpu32_pkg.sv
// cpu32 shared types and constants.
// Used by fetch, next-PC select and control32.
package cpu32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic jrn;
    logic jmp;
    logic jal;
    logic branch;
    logic nbranch;
  } flow_t;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_sel32.sv
// Next-PC select: jr, j/jal, branch, sequential.
// Purely combinational; fetch samples it on retire.
module npc_sel32
  import cpu32_pkg::*;
(
  input  logic [31:0] pc_plus_4,
  input  logic [25:0] instr_index,
  input  flow_t       flow,
  input  logic        zero,
  input  logic [31:0] read_data_1,
  output logic [31:0] next_pc
);

  logic        take;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;

  assign take = (flow.branch & zero)
              | (flow.nbranch & ~zero);

  assign br_tgt = pc_plus_4
                + br_off(instr_index[15:0]);

  assign j_tgt = {pc_plus_4[31:28],
                  instr_index, 2'b00};

  assign jr_tgt = read_data_1 & 32'hFFFF_FFFC;

  // Priority: jr over j/jal over taken branch.
  always_comb begin
    next_pc = pc_plus_4;
    if (flow.jrn)
      next_pc = jr_tgt;
    else if (flow.jmp | flow.jal)
      next_pc = j_tgt;
    else if (take)
      next_pc = br_tgt;
  end

endmodule

// File: rtl/ifetch32_seq.sv
// Sequential fetch stage: PC, imem handshake,
// held instruction register feeding control32.
module ifetch32_seq
  import cpu32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic [5:0]         Opcode,
  output logic [5:0]         Function_opcode,
  output logic               instr_valid,
  input  logic               stall,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus_4,
  input  logic               Jrn,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Zero,
  input  logic [31:0]        Read_data_1
);

  fetch_state_t state;
  flow_t        flow;
  logic [31:0]  next_pc;

  assign flow = {Jrn, Jmp, Jal,
                 Branch, nBranch};

  assign pc_plus_4 = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];

  assign Opcode          = instruction[31:26];
  assign Function_opcode = instruction[5:0];

  npc_sel32 u_npc (
    .pc_plus_4   (pc_plus_4),
    .instr_index (instruction[25:0]),
    .flow        (flow),
    .zero        (Zero),
    .read_data_1 (Read_data_1),
    .next_pc     (next_pc)
  );

  // Fetch FSM: request, hold for decode, retire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          imem_req <= 1'b1;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (imem_ready) begin
            instruction <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
